// File: rtl/turing_eraser.sv
// turing_eraser
//   Tape machine that scans upward from cell 0 (LSB), clears the first cell
//   holding 1 and halts. An all-zero tape halts with fail_reg set. The result
//   is held while ready stays high. Dropping ready releases the machine back
//   to IDLE, so it can be rerun without a reset.
//
// Ports
//   clk              : clock, rising edge
//   reset            : asynchronous active-high reset
//   ready            : level start / hold request
//   tape_reg_input   : tape image to load (sampled every IDLE edge)
//   tape_reg         : working tape
//   index_reg        : head position
//   turing_state_reg : 0 = running or idle, 1 = halted
//   done_reg         : result valid
//   fail_reg         : tape held no 1 (qualified by done_reg)
//   steps_reg        : cells examined in the last run
//   busy             : high while scanning
module turing_eraser #(
    parameter int WIDTH = 8,
    parameter int IW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ready,
    input  logic [WIDTH-1:0] tape_reg_input,
    output logic [WIDTH-1:0] tape_reg,
    output logic [IW-1:0]    index_reg,
    output logic             turing_state_reg,
    output logic             done_reg,
    output logic             fail_reg,
    output logic [IW:0]      steps_reg,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic w_cell;
    logic w_last;

    assign w_cell = tape_reg[index_reg];
    assign w_last = (index_reg == IW'(WIDTH - 1));
    assign busy   = (r_state == S_SCAN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (ready) w_next = S_SCAN;
            S_SCAN: if (w_cell || w_last) w_next = S_HALT;
            S_HALT: if (!ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tape_reg         <= '0;
            index_reg        <= '0;
            steps_reg        <= '0;
            turing_state_reg <= 1'b0;
            done_reg         <= 1'b0;
            fail_reg         <= 1'b0;
        end else begin
            case (r_state)
                S_SCAN: begin
                    steps_reg <= steps_reg + {{IW{1'b0}}, 1'b1};
                    if (w_cell) begin
                        // Head stays on the cleared cell so the result points at it.
                        tape_reg[index_reg] <= 1'b0;
                        turing_state_reg    <= 1'b1;
                        done_reg            <= 1'b1;
                    end else if (w_last) begin
                        // Top cell reached without a 1: stop here, never wrap.
                        fail_reg         <= 1'b1;
                        done_reg         <= 1'b1;
                        turing_state_reg <= 1'b1;
                    end else begin
                        index_reg <= index_reg + {{(IW-1){1'b0}}, 1'b1};
                    end
                end
                S_HALT: begin
                    // Result holds while ready is high; release reloads the tape.
                    if (!ready) begin
                        tape_reg         <= tape_reg_input;
                        turing_state_reg <= 1'b0;
                        done_reg         <= 1'b0;
                        fail_reg         <= 1'b0;
                    end
                end
                default: begin
                    // IDLE (and any stray encoding): track the input tape.
                    tape_reg         <= tape_reg_input;
                    index_reg        <= '0;
                    steps_reg        <= '0;
                    turing_state_reg <= 1'b0;
                    done_reg         <= 1'b0;
                    fail_reg         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/turing_eraser.md
# turing_eraser

Companion tape machine that runs the scan the other way: starting at tape cell 0 (LSB), it walks the head upward, clears the first cell holding 1, and halts. It undoes the "set a cell" action of the existing MSB-down marker machine and uses the same load/ready/done tape interface, so both machines can share a test harness and a tape source. It adds a fail flag for an all-zero tape and a release handshake, so it can be rerun without a reset.

## Interface
Parameters:
- WIDTH, default 8: tape length in cells; must be ≥2.
- IW, default $clog2(WIDTH): head index width.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high; forces the reset state immediately.
- ready  input  1  level start/hold request.
- tape_reg_input  input  WIDTH  tape image to load.
- tape_reg  output  WIDTH  working tape (registered).
- index_reg  output  IW  head position (registered).
- turing_state_reg  output  1  machine state: 0 = running or idle, 1 = halted.
- done_reg  output  1  result valid.
- fail_reg  output  1  tape contained no 1; qualified by done_reg.
- steps_reg  output  IW+1  number of cells examined in the last run.
- busy  output  1  high in SCAN only.

## Operation
- Control FSM has three states: IDLE, SCAN and HALT. Encoding is free; unused encodings go to IDLE.
- Reset (asynchronous) sets:
  - FSM to IDLE;
  - tape_reg, index_reg and steps_reg to 0;
  - turing_state_reg, done_reg, fail_reg and busy to 0.
- IDLE:
  - each edge: tape_reg ← tape_reg_input; index_reg ← 0; steps_reg ← 0; turing_state_reg, done_reg and fail_reg ← 0.
  - ready=1 at an edge: go to SCAN. The tape captured at that edge is the tape processed.
- SCAN, one cell per edge, using the current tape_reg[index_reg]; steps_reg increments on every SCAN edge:
  - cell = 1: clear that cell; set turing_state_reg=1 and done_reg=1; go to HALT. index_reg stays at the cleared cell.
  - cell = 0 and index_reg = WIDTH-1: set fail_reg=1, done_reg=1 and turing_state_reg=1; go to HALT. Tape unchanged; index_reg stays at WIDTH-1.
  - cell = 0 otherwise: index_reg ← index_reg+1.
- ready changes during SCAN are ignored.
- index_reg never wraps; the WIDTH-1 check stops the scan first.
- HALT:
  - all outputs hold while ready=1.
  - ready=0 at an edge: go to IDLE. On that same edge done_reg, fail_reg and turing_state_reg clear and tape_reg reloads from the input.
- Only one cell is ever cleared per run; bits above the cleared cell are never touched.

## Timing
- Let E0 be the edge that samples ready=1 in IDLE.
- Cell i is examined at edge E0+1+i.
- For a first set bit at position p:
  - done_reg, the cleared tape and turing_state_reg are all visible after edge E0+1+p, in the same cycle;
  - latency is p+2 edges counting E0;
  - steps_reg = p+1.
- All-zero tape: done_reg=1 and fail_reg=1 after edge E0+WIDTH; steps_reg = WIDTH.
- busy is high from after E0 until the HALT transition edge.
- Minimum rerun interval: one edge in HALT with ready=0, one edge in IDLE with ready=1, then the scan.
- Reset asserted mid-SCAN or in HALT: reset values appear immediately, with no clock needed. After deassertion the machine starts in IDLE.

## Test plan
- Bit 2 set: load 8'b1011_0100, pulse ready high.
  - Response: after E0+3, tape_reg=8'b1011_0000, index_reg=2, steps_reg=3, done_reg=1, fail_reg=0, turing_state_reg=1.
- LSB and MSB boundaries:
  - 8'h01 → 8'h00, index 0, done after E0+1.
  - 8'h80 → 8'h00, index 7, done after E0+8, steps_reg=8.
  - 8'hFF → 8'hFE, index 0.
- All-zero tape: 8'h00 → after E0+8, done_reg=1, fail_reg=1, tape_reg=8'h00, index_reg=7.
- Hold and release:
  - Keep ready=1 for 10 cycles in HALT: outputs stable.
  - Drop ready: next edge done_reg=0 and tape_reg follows the input.
  - Raise ready with 8'h10: done after E0+5, result 8'h00.
- Async reset at E0+2 while scanning 8'h40: outputs go to 0 before the next edge. No done pulse until a new ready.
- Input change mid-scan: change tape_reg_input from 8'h08 to 8'h01 at E0+1, while scanning 8'h08.
  - Required: result 8'h00 at index 3 (the tape captured at E0 governs), not index 0.
